// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver: time-multiplexed common-anode seven-segment display driver
// Ports:
//   clk_i, rst_ni  : clock and synchronous active-low reset
//   value_i, dp_i  : digit nibbles (digit 0 least significant) and decimal-point enables
//   load_i         : one-cycle strobe capturing value_i/dp_i, displayed from the next frame
//   lz_blank_i     : leading-zero suppression enable, applied live
//   seg_o, dp_n_o  : active-low segments {a..g} (bit6 = a) and decimal point
//   an_o           : active-low one-hot-cold anode enables
//   frame_start_o  : pulse on the first output cycle of digit 0's slot
module seven_seg_mux_driver #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 2,
   parameter int HEX_MODE     = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [4*DIGITS-1:0]   value_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic                  load_i,
   input  logic                  lz_blank_i,
   output logic [6:0]            seg_o,
   output logic                  dp_n_o,
   output logic [DIGITS-1:0]     an_o,
   output logic                  frame_start_o
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [DIGITS-1:0][3:0] pv_q, pv_d, sv_q, sv_d;
   logic [DIGITS-1:0]      pdp_q, pdp_d, sdp_q, sdp_d;
   logic                   pend_q, pend_d;
   logic [6:0]             seg_q, seg_d;
   logic                   dpn_q, dpn_d;
   logic [DIGITS-1:0]      an_q, an_d;
   logic                   fs_q, fs_d;
   logic                   slot_end, boundary, lead, supp;
   logic [DIGITS-1:0]      lz;
   logic [3:0]             nib;
   logic [6:0]             glyph;
   always_comb begin
      slot_end = cnt_q == CW'(REFRESH_DIV - 1);
      boundary = slot_end && idx_q == IW'(DIGITS - 1);
      cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
      idx_d    = !slot_end ? idx_q : boundary ? '0 : idx_q + IW'(1);
      pv_d     = load_i ? value_i : pv_q;
      pdp_d    = load_i ? dp_i : pdp_q;
      pend_d   = !boundary && (pend_q || load_i);
      // a load coinciding with the boundary bypasses the pending stage
      sv_d     = boundary && load_i ? value_i : boundary && pend_q ? pv_q : sv_q;
      sdp_d    = boundary && load_i ? dp_i : boundary && pend_q ? pdp_q : sdp_q;
   end
   always_comb begin
      // lz[k] is set when nibble k and every higher nibble are zero
      lz   = '0;
      lead = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         lead  = lead && sv_q[k] == 4'd0;
         lz[k] = lead;
      end
      nib  = sv_q[idx_q];
      supp = lz_blank_i && lz[idx_q] && idx_q != '0 && !sdp_q[idx_q];
      case (nib)
         4'h0: glyph = 7'b0000001;
         4'h1: glyph = 7'b1001111;
         4'h2: glyph = 7'b0010010;
         4'h3: glyph = 7'b0000110;
         4'h4: glyph = 7'b1001100;
         4'h5: glyph = 7'b0100100;
         4'h6: glyph = 7'b0100000;
         4'h7: glyph = 7'b0001111;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0000100;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b1100000;
         4'hC: glyph = 7'b0110001;
         4'hD: glyph = 7'b1000010;
         4'hE: glyph = 7'b0110000;
         default: glyph = 7'b0111000;
      endcase
      if (HEX_MODE == 0 && nib > 4'd9) glyph = 7'h7F;
      seg_d = supp ? 7'h7F : glyph;
      dpn_d = supp || !sdp_q[idx_q];
      an_d  = '1;
      if (cnt_q >= CW'(BLANK_CYCLES)) an_d[idx_q] = 1'b0;
      fs_d  = cnt_q == '0 && idx_q == '0;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         pv_q   <= '0;
         pdp_q  <= '0;
         sv_q   <= '0;
         sdp_q  <= '0;
         pend_q <= 1'b0;
         seg_q  <= 7'h7F;
         dpn_q  <= 1'b1;
         an_q   <= '1;
         fs_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         pv_q   <= pv_d;
         pdp_q  <= pdp_d;
         sv_q   <= sv_d;
         sdp_q  <= sdp_d;
         pend_q <= pend_d;
         seg_q  <= seg_d;
         dpn_q  <= dpn_d;
         an_q   <= an_d;
         fs_q   <= fs_d;
      end
   end
   assign seg_o         = seg_q;
   assign dp_n_o        = dpn_q;
   assign an_o          = an_q;
   assign frame_start_o = fs_q;
endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// tb_seven_seg_mux_driver: checks decimal and hex variants of the display driver
// against a cycle-count based model of the scan, frame-synchronous loads and glyphs.
module tb_seven_seg_mux_driver;
   logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, lz_blank = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic [6:0]  seg0, seg1;
   logic        dpn0, dpn1, fs0, fs1;
   logic [3:0]  an0, an1;
   int          checks = 0, failures = 0;
   int          m_n = 0;
   logic [15:0] m_sv = '0, m_pv = '0;
   logic [3:0]  m_sdp = '0, m_pdp = '0;
   logic        m_pend = 1'b0;
   logic [6:0]  glyph_tab [16];

   always #5 clk = ~clk;

   seven_seg_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0)) dut_dec (
      .clk_i(clk), .rst_ni(rst_n), .value_i(value), .dp_i(dp), .load_i(load),
      .lz_blank_i(lz_blank), .seg_o(seg0), .dp_n_o(dpn0), .an_o(an0), .frame_start_o(fs0));
   seven_seg_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1)) dut_hex (
      .clk_i(clk), .rst_ni(rst_n), .value_i(value), .dp_i(dp), .load_i(load),
      .lz_blank_i(lz_blank), .seg_o(seg1), .dp_n_o(dpn1), .an_o(an1), .frame_start_o(fs1));

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // digit d of shadow v: suppressed leading zero, out-of-range nibble, or table glyph
   function automatic logic [6:0] exp_seg(input int d, input logic [15:0] v, input logic [3:0] dpv,
                                          input logic lz, input logic hex);
      int nib;
      nib = int'((v >> (4 * d)) & 16'hF);
      if (lz && d != 0 && !dpv[d] && (v >> (4 * d)) == 16'd0) return 7'h7F;
      if (nib > 9 && !hex) return 7'h7F;
      return glyph_tab[nib];
   endfunction

   // one clock: predict outputs from the pre-edge model state, advance model, compare
   task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
      int         pos, dg, c;
      logic [6:0] es0, es1;
      logic       edp, efs;
      logic [3:0] ean;
      pos = m_n % 16;
      dg  = pos / 4;
      c   = pos % 4;
      load = ld;
      value = v;
      dp = d;
      if (!rst_n) begin
         es0 = 7'h7F; es1 = 7'h7F; edp = 1'b1; efs = 1'b0; ean = 4'hF;
      end else begin
         es0 = exp_seg(dg, m_sv, m_sdp, lz_blank, 1'b0);
         es1 = exp_seg(dg, m_sv, m_sdp, lz_blank, 1'b1);
         edp = !m_sdp[dg];
         efs = pos == 0;
         ean = c == 0 ? 4'hF : 4'hF ^ (4'b0001 << dg);
      end
      @(posedge clk);
      if (!rst_n) begin
         m_n = 0; m_sv = '0; m_pv = '0; m_sdp = '0; m_pdp = '0; m_pend = 1'b0;
      end else begin
         if (pos == 15) begin
            if (ld) begin m_sv = v; m_sdp = d; end
            else if (m_pend) begin m_sv = m_pv; m_sdp = m_pdp; end
            m_pend = 1'b0;
         end else if (ld) m_pend = 1'b1;
         if (ld) begin m_pv = v; m_pdp = d; end
         m_n++;
      end
      #1;
      check("seg_dec", seg0, es0);
      check("seg_hex", seg1, es1);
      check("dp_n_dec", 7'(dpn0), 7'(edp));
      check("dp_n_hex", 7'(dpn1), 7'(edp));
      check("an_dec", 7'(an0), 7'(ean));
      check("an_hex", 7'(an1), 7'(ean));
      check("frame_start_dec", 7'(fs0), 7'(efs));
      check("frame_start_hex", 7'(fs1), 7'(efs));
      load = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom));
   endtask

   task automatic goto(input int p);
      for (int i = 0; i < 16 && m_n % 16 != p; i++) step(1'b0, 16'($urandom), 4'($urandom));
   endtask

   initial begin
      logic [15:0] v;
      glyph_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) step(1'($urandom), 16'($urandom), 4'($urandom));
      rst_n = 1'b1;
      step(1'b1, 16'h1234, 4'h0);
      run(35);
      goto(6);
      step(1'b1, 16'h5678, 4'h0);
      run(30);
      goto(3);
      step(1'b1, 16'($urandom), 4'($urandom));
      run(4);
      step(1'b1, 16'($urandom), 4'($urandom));
      run(30);
      goto(15);
      step(1'b1, 16'h9A0B, 4'h5);
      run(20);
      lz_blank = 1'b1;
      goto(2);
      step(1'b1, 16'h0070, 4'h0);
      run(34);
      goto(2);
      step(1'b1, 16'h0070, 4'b0100);
      run(34);
      goto(2);
      step(1'b1, 16'h0000, 4'h0);
      run(30);
      lz_blank = 1'b0;
      step(1'b1, 16'hABCF, 4'h0);
      run(34);
      for (int i = 0; i < 300; i++) begin
         lz_blank = 1'($urandom);
         v = 16'($urandom);
         if ($urandom % 2 == 0) v = v >> (4 * ($urandom % 4));
         step($urandom % 6 == 0, v, 4'($urandom));
      end
      lz_blank = 1'b0;
      goto(5);
      step(1'b1, 16'h4321, 4'hF);
      goto(9);
      rst_n = 1'b0;
      step(1'b0, 16'($urandom), 4'($urandom));
      step(1'b1, 16'($urandom), 4'($urandom));
      rst_n = 1'b1;
      run(40);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
